rs232_tx: RTL and testbench
===========================

# rs232_tx

Avalon-MM master that drains a byte stream into the TX data register of the board's RS232 UART core, polling the UART status register before every write. It is the transmit counterpart of the existing RS232 receive path and sits between the result/pixel producer and the UART. It buffers bytes in a small internal FIFO, counts transmitted bytes per frame and pulses a frame-done flag.

## Interface
Parameters:
- FIFO_DEPTH, 16: input FIFO entries; power of two, at least 2.
- FRAME_BYTES, 150000: payload bytes per frame; at least 1.

Ports:
- avm_clk  in  1  clock.
- avm_rst  in  1  reset; asynchronous, active-low.
- avm_address  out  5  UART register byte address: RX=0, TX=4, STATUS=8.
- avm_read  out  1  Avalon read request.
- avm_readdata  in  32  read data; status bit 6 = TX ready.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  {24'b0, byte}.
- avm_waitrequest  in  1  slave stall; the request is held while it is 1.
- in_data  in  8  byte from producer.
- in_valid  in  1  in_data valid.
- in_ready  out  1  = FIFO not full; a push happens when in_valid and in_ready are both 1.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- tx_done  out  1  one-cycle pulse after the last payload byte of a frame is accepted.

## Operation
- All Avalon outputs and tx_done are registered. avm_read and avm_write are never high together.
- Reset values:
  - avm_read=0, avm_write=0, avm_address=8, avm_writedata=0.
  - tx_done=0, FIFO empty, fifo_level=0, in_ready=1.
  - Byte counter 0, state S_IDLE.
- S_IDLE: no request is driven. If the FIFO is non-empty, drive read @8 and go to S_POLL.
- S_POLL: hold read @8 while waitrequest=1. On the accept cycle (waitrequest=0):
  - If readdata[6]=1: drive write @4 with the FIFO head in writedata[7:0], and go to S_WRITE.
  - Otherwise keep read @8 asserted, which re-issues the poll back-to-back.
- S_WRITE: hold write, address and data stable while waitrequest=1. On the accept cycle:
  - Pop the FIFO and increment the counter.
  - If the FIFO is non-empty after the pop, drive read @8 and go to S_POLL; otherwise go to S_IDLE with read and write at 0.
- Counter: width $clog2(FRAME_BYTES+1). When the accepted write has counter==FRAME_BYTES-1, the counter wraps to 0 and tx_done=1 for the next cycle.
- FIFO: circular buffer with read and write pointers. Push and pop in the same cycle leave the level unchanged. There is no push when full (in_ready=0) and no pop when empty, because S_WRITE is entered only with a non-empty FIFO.
- The FIFO head is sampled when the write is launched and is not re-read while the write is stalled.
- Reset mid-transfer: all state is discarded immediately and the FIFO contents are lost. After release the block behaves as after power-up.

## Timing
- Push at edge N: fifo_level updates at N, and avm_read rises at N+1 if the block was idle.
- Minimum per byte with waitrequest=0 and TX ready: 1 poll cycle + 1 write cycle = 2 cycles per byte.
- Every additional waitrequest cycle or not-ready poll adds exactly 1 cycle.
- tx_done is high exactly 1 cycle after the final write accept of a frame.
- in_ready is combinational from fifo_level only, with no path from in_valid.

## Configuration
- RS232_TX_HEADER_EN defined:
  - When the counter is 0 and the frame header is not yet sent, the first S_POLL/S_WRITE pair writes 0xA5 without popping the FIFO.
  - A sent-header flag is set on that write's accept and cleared at frame wrap.
  - The header is not counted in FRAME_BYTES and is still gated by a non-empty FIFO.
- RS232_TX_HEADER_EN undefined: no header; only payload bytes are written.

## Test plan
- Reset with avm_rst=0 for 3 cycles:
  - All outputs at reset values; in_ready=1; no request for 10 idle cycles.
- Push 0x3C, status always 0x40, waitrequest=0:
  - read @8 at N+1, then write @4 with data 0x0000003C at N+2, then idle.
- Status returns 0x00 for 5 polls, then 0x40:
  - exactly 6 reads @8 before one write.
  - With waitrequest=1 for 3 cycles during the write, address and data stay stable.
- Push 20 bytes 0..19 with FIFO_DEPTH=16 while TX is held not-ready:
  - in_ready=0 at fifo_level=16.
  - After TX is released, bytes 0..19 are written in order with no loss or duplication.
- FRAME_BYTES=4, send 9 bytes:
  - tx_done pulses after the 4th and 8th writes, each pulse 1 cycle; the counter ends at 1.
  - With RS232_TX_HEADER_EN defined, 0xA5 precedes bytes 1, 5 and 9.
- Assert reset while a write is stalled:
  - avm_write=0 immediately, FIFO empty.
  - After release, a new push is sent normally.

Source files
------------

// File: rtl/rs232_tx.sv
// rs232_tx: Avalon-MM master that drains a byte FIFO into the RS232 UART TX
// data register. It polls the UART status register (bit 6 = TX ready) before
// every byte, counts payload bytes per frame and pulses tx_done after the
// last byte of each frame.
//
// Optional feature: define RS232_TX_HEADER_EN to prefix every frame with a
// 0xA5 header byte. The header does not pop the FIFO and is not counted.
//
// Ports:
//   avm_clk, avm_rst      clock, asynchronous active-low reset
//   avm_address           UART register byte address (TX=4, STATUS=8)
//   avm_read/avm_write    Avalon requests (registered, never both high)
//   avm_readdata          status read data, bit 6 = TX ready
//   avm_writedata         {24'b0, byte}
//   avm_waitrequest       slave stall; the request is held while high
//   in_data/in_valid      producer byte stream
//   in_ready              FIFO not full (combinational from fifo_level)
//   fifo_level            current FIFO occupancy
//   tx_done               one-cycle pulse after the last byte of a frame
module rs232_tx #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned FRAME_BYTES = 150000
) (
    input  logic                          avm_clk,
    input  logic                          avm_rst,
    output logic [4:0]                    avm_address,
    output logic                          avm_read,
    input  logic [31:0]                   avm_readdata,
    output logic                          avm_write,
    output logic [31:0]                   avm_writedata,
    input  logic                          avm_waitrequest,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          tx_done
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(FRAME_BYTES + 1);

    localparam logic [4:0]    ADDR_TX     = 5'd4;
    localparam logic [4:0]    ADDR_STATUS = 5'd8;
    localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);
    localparam logic [CW-1:0] LAST_CNT    = CW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_POLL,
        S_WRITE
    } state_t;

    state_t          state_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic [CW-1:0]   cnt_q;
    logic            push;
    logic            pop;
    logic            wr_accept;
`ifdef RS232_TX_HEADER_EN
    logic            hdr_sent_q;
    logic            hdr_wr_q;
`endif

    // Only the TX-ready bit of the status word is used.
    logic unused_readdata;
    assign unused_readdata = ^{avm_readdata[31:7], avm_readdata[5:0]};

    assign in_ready   = (level_q != FULL_LEVEL);
    assign fifo_level = level_q;

    // FIFO push/pop qualification and next occupancy.
    always_comb begin
        wr_accept = avm_write && !avm_waitrequest;
        push      = in_valid && in_ready;
`ifdef RS232_TX_HEADER_EN
        pop       = wr_accept && !hdr_wr_q;
`else
        pop       = wr_accept;
`endif
        level_d   = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (!push && pop) begin
            level_d = level_q - LW'(1);
        end
    end

    // FIFO storage; contents are meaningless after reset, so no reset here.
    always_ff @(posedge avm_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Control FSM, FIFO pointers, frame counter and registered outputs.
    always_ff @(posedge avm_clk or negedge avm_rst) begin
        if (!avm_rst) begin
            state_q       <= S_IDLE;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            level_q       <= '0;
            cnt_q         <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_address   <= ADDR_STATUS;
            avm_writedata <= '0;
            tx_done       <= 1'b0;
`ifdef RS232_TX_HEADER_EN
            hdr_sent_q    <= 1'b0;
            hdr_wr_q      <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            level_q <= level_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (level_q != '0) begin
                        avm_read    <= 1'b1;
                        avm_address <= ADDR_STATUS;
                        state_q     <= S_POLL;
                    end
                end
                S_POLL: begin
                    // A not-ready status simply leaves the read asserted,
                    // which re-issues the poll on the next cycle.
                    if (!avm_waitrequest && avm_readdata[6]) begin
                        avm_read    <= 1'b0;
                        avm_write   <= 1'b1;
                        avm_address <= ADDR_TX;
                        state_q     <= S_WRITE;
`ifdef RS232_TX_HEADER_EN
                        if ((cnt_q == '0) && !hdr_sent_q) begin
                            avm_writedata <= {24'h0, 8'hA5};
                            hdr_wr_q      <= 1'b1;
                        end else begin
                            avm_writedata <= {24'h0, mem_q[rd_ptr_q]};
                        end
`else
                        avm_writedata <= {24'h0, mem_q[rd_ptr_q]};
`endif
                    end
                end
                S_WRITE: begin
                    if (!avm_waitrequest) begin
                        avm_write <= 1'b0;
`ifdef RS232_TX_HEADER_EN
                        if (hdr_wr_q) begin
                            hdr_wr_q   <= 1'b0;
                            hdr_sent_q <= 1'b1;
                        end else if (cnt_q == LAST_CNT) begin
                            cnt_q      <= '0;
                            tx_done    <= 1'b1;
                            hdr_sent_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
`else
                        if (cnt_q == LAST_CNT) begin
                            cnt_q   <= '0;
                            tx_done <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
`endif
                        avm_address <= ADDR_STATUS;
                        if (level_d != '0) begin
                            avm_read <= 1'b1;
                            state_q  <= S_POLL;
                        end else begin
                            state_q  <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs232_tx.sv
// tb_rs232_tx: directed and randomized bench for rs232_tx with a UART slave
// model, a byte-stream reference model and immediate-assertion checks.
module tb_rs232_tx;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned FB    = 4;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;
`ifdef RS232_TX_HEADER_EN
    localparam logic HDR = 1'b1;
`else
    localparam logic HDR = 1'b0;
`endif

    logic          avm_clk;
    logic          avm_rst;
    logic [4:0]    avm_address;
    logic          avm_read;
    logic [31:0]   avm_readdata;
    logic          avm_write;
    logic [31:0]   avm_writedata;
    logic          avm_waitrequest;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic [LW-1:0] fifo_level;
    logic          tx_done;

    rs232_tx #(.FIFO_DEPTH(DEPTH), .FRAME_BYTES(FB)) dut (
        .avm_clk(avm_clk), .avm_rst(avm_rst),
        .avm_address(avm_address), .avm_read(avm_read),
        .avm_readdata(avm_readdata), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_waitrequest(avm_waitrequest),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .fifo_level(fifo_level), .tx_done(tx_done)
    );

    initial avm_clk = 1'b0;
    always #5 avm_clk = ~avm_clk;

    // Slave knobs, written only by the stimulus block.
    logic hold_tx;
    logic rnd_en;
    int   notrdy_until;
    int   wr_stall_until;

    // Slave/monitor state, written only by the monitor block.
    int          cyc = 0;
    int          polls_total = 0;
    int          wr_stall_total = 0;
    int          last_wr_cyc = 0;
    int          proto_err = 0;
    logic        rnd_wait_q = 1'b0;
    logic        rnd_nr_q = 1'b0;
    logic        prev_stall = 1'b0;
    logic        prev_rd = 1'b0;
    logic        prev_wr = 1'b0;
    logic        prev_done = 1'b0;
    logic [4:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;
    logic [31:0] wq[$];
    int          done_q[$];
    int          lag_q[$];

    logic status_ready;
    assign status_ready    = !hold_tx && (polls_total >= notrdy_until) && !rnd_nr_q;
    assign avm_readdata    = status_ready ? 32'h0000_0040 : 32'hFFFF_FFBF;
    assign avm_waitrequest = avm_rst &&
        ((avm_write && (wr_stall_total < wr_stall_until)) ||
         ((avm_read || avm_write) && rnd_wait_q));

    // UART slave model and bus monitor.
    always @(posedge avm_clk) begin
        if (avm_rst) begin
            cyc        <= cyc + 1;
            rnd_wait_q <= rnd_en && ($urandom_range(0, 2) == 0);
            rnd_nr_q   <= rnd_en && ($urandom_range(0, 2) == 0);
            if (avm_read && avm_write) proto_err <= proto_err + 1;
            if (avm_read && avm_address != 5'd8) proto_err <= proto_err + 1;
            if (avm_write && (avm_address != 5'd4 || avm_writedata[31:8] != 24'h0))
                proto_err <= proto_err + 1;
            if (prev_stall && (avm_read != prev_rd || avm_write != prev_wr ||
                               avm_address != prev_addr ||
                               (prev_wr && avm_writedata != prev_data)))
                proto_err <= proto_err + 1;
            if (avm_read && !avm_waitrequest) polls_total <= polls_total + 1;
            if (avm_write && (wr_stall_total < wr_stall_until))
                wr_stall_total <= wr_stall_total + 1;
            if (avm_write && !avm_waitrequest) begin
                wq.push_back(avm_writedata);
                last_wr_cyc <= cyc + 1;
            end
            if (tx_done) begin
                done_q.push_back(wq.size());
                lag_q.push_back(cyc + 1 - last_wr_cyc);
                if (prev_done) proto_err <= proto_err + 1;
            end
            prev_done  <= tx_done;
            prev_stall <= (avm_read || avm_write) && avm_waitrequest;
            prev_rd    <= avm_read;
            prev_wr    <= avm_write;
            prev_addr  <= avm_address;
            prev_data  <= avm_writedata;
        end else begin
            prev_stall <= 1'b0;
            prev_done  <= 1'b0;
        end
    end

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: expected write stream and tx_done positions.
    logic [31:0] exp_wq[$];
    int          exp_done[$];
    int          pay_cnt = 0;
    int          chk_idx = 0;
    int          done_idx = 0;

    task automatic model_push(input logic [7:0] b);
        if (HDR && (pay_cnt % FB == 0)) exp_wq.push_back(32'h0000_00A5);
        exp_wq.push_back({24'h0, b});
        pay_cnt++;
        if (pay_cnt % FB == 0) exp_done.push_back(exp_wq.size());
    endtask

    task automatic tick();
        @(posedge avm_clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((wq.size() < exp_wq.size() || fifo_level != '0 || avm_read || avm_write)
               && n < 5000) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < 5000), 32'd1);
        repeat (4) tick();
    endtask

    task automatic compare(input string tag);
        check({tag, "_wcount"}, wq.size(), exp_wq.size());
        for (int i = chk_idx; i < exp_wq.size() && i < wq.size(); i++)
            check($sformatf("%s_w%0d", tag, i), wq[i], exp_wq[i]);
        chk_idx = exp_wq.size();
        check({tag, "_dcount"}, done_q.size(), exp_done.size());
        for (int i = done_idx; i < exp_done.size() && i < done_q.size(); i++) begin
            check($sformatf("%s_dpos%0d", tag, i), done_q[i], exp_done[i]);
            check($sformatf("%s_dlag%0d", tag, i), lag_q[i], 32'd1);
        end
        done_idx = exp_done.size();
    endtask

    initial begin
        int base, rd0, st0, push_cyc, k, guard, full_cyc, d0, n;
        logic rdy;
        avm_rst = 1'b0;
        in_data = 8'h00;
        in_valid = 1'b0;
        hold_tx = 1'b0;
        rnd_en = 1'b0;
        notrdy_until = 0;
        wr_stall_until = 0;

        // Reset state and idle behaviour.
        repeat (3) tick();
        check("rst_read", 32'(avm_read), 32'd0);
        check("rst_write", 32'(avm_write), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd8);
        check("rst_wdata", avm_writedata, 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        avm_rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle_req%0d", i), 32'({avm_read, avm_write}), 32'd0);
        end

        // Single byte, exact cycle timing.
        base = wq.size();
        in_data = 8'h3C;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        model_push(8'h3C);
        check("t2_level_n", 32'(fifo_level), 32'd1);
        check("t2_read_n", 32'(avm_read), 32'd0);
        tick();
        check("t2_read_n1", 32'(avm_read), 32'd1);
        check("t2_addr_n1", 32'(avm_address), 32'd8);
        check("t2_write_n1", 32'(avm_write), 32'd0);
        tick();
        check("t2_write_n2", 32'(avm_write), 32'd1);
        check("t2_read_n2", 32'(avm_read), 32'd0);
        check("t2_addr_n2", 32'(avm_address), 32'd4);
        check("t2_data_n2", avm_writedata, exp_wq[base]);
        tick();
        check("t2_write_n3", 32'(avm_write), 32'd0);
        check("t2_read_n3", 32'(avm_read), 32'(HDR));
        drain("t2");
        compare("t2");

        // Five not-ready polls, then a write stalled for three cycles.
        rd0 = polls_total;
        st0 = wr_stall_total;
        notrdy_until = polls_total + 5;
        wr_stall_until = wr_stall_total + 3;
        in_data = 8'h7E;
        in_valid = 1'b1;
        tick();
        push_cyc = cyc;
        in_valid = 1'b0;
        model_push(8'h7E);
        drain("t3");
        check("t3_polls", polls_total - rd0, 32'd6);
        check("t3_stalls", wr_stall_total - st0, 32'd3);
        check("t3_latency", last_wr_cyc - push_cyc, 32'd11);
        check("t3_proto", proto_err, 32'd0);
        compare("t3");

        // Fill the FIFO while TX is not ready, then release.
        hold_tx = 1'b1;
        k = 0;
        guard = 0;
        full_cyc = 0;
        while (k < 20 && guard < 400) begin
            in_data = 8'(k);
            in_valid = 1'b1;
            rdy = in_ready;
            tick();
            guard++;
            if (rdy) begin
                model_push(in_data);
                k++;
            end
            if (fifo_level == LW'(DEPTH)) begin
                full_cyc++;
                if (full_cyc == 1) check("t4_ready_full", 32'(in_ready), 32'd0);
                if (full_cyc == 5) begin
                    check("t4_level_full", 32'(fifo_level), 32'd16);
                    hold_tx = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        check("t4_loop", 32'(guard < 400), 32'd1);
        check("t4_saw_full", 32'(full_cyc >= 5), 32'd1);
        drain("t4");
        compare("t4");

        // Randomized traffic with random stalls and not-ready polls.
        rnd_en = 1'b1;
        n = $urandom_range(30, 60);
        k = 0;
        guard = 0;
        while (k < n && guard < 3000) begin
            in_data = 8'($urandom);
            in_valid = ($urandom_range(0, 1) == 1);
            rdy = in_ready && in_valid;
            tick();
            guard++;
            if (rdy) begin
                model_push(in_data);
                k++;
            end
        end
        in_valid = 1'b0;
        rnd_en = 1'b0;
        check("t5_loop", 32'(guard < 3000), 32'd1);
        drain("t5");
        compare("t5");

        // Reset while a write is stalled: FIFO contents are dropped.
        wr_stall_until = wr_stall_total + 1000000;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'hE0 + i);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        guard = 0;
        while (!avm_write && guard < 50) begin
            tick();
            guard++;
        end
        check("t6_write_seen", 32'(avm_write), 32'd1);
        repeat (2) tick();
        avm_rst = 1'b0;
        #1;
        check("t6_write_rst", 32'(avm_write), 32'd0);
        check("t6_read_rst", 32'(avm_read), 32'd0);
        check("t6_level_rst", 32'(fifo_level), 32'd0);
        check("t6_ready_rst", 32'(in_ready), 32'd1);
        check("t6_addr_rst", 32'(avm_address), 32'd8);
        pay_cnt = 0;
        repeat (2) tick();
        wr_stall_until = wr_stall_total;
        avm_rst = 1'b1;
        repeat (3) tick();
        check("t6_idle", 32'({avm_read, avm_write}), 32'd0);
        check("t6_nowrite", wq.size(), exp_wq.size());

        // Nine bytes after reset: pulses after the 4th and 8th bytes.
        d0 = done_q.size();
        for (int i = 0; i < 9; i++) begin
            in_data = 8'(8'h10 + i);
            in_valid = 1'b1;
            tick();
            model_push(in_data);
        end
        in_valid = 1'b0;
        drain("t7");
        check("t7_pulses", done_q.size() - d0, 32'd2);
        compare("t7");

        // Counter left at 1: three more bytes complete the next frame.
        d0 = done_q.size();
        for (int i = 0; i < 3; i++) begin
            in_data = 8'(8'h40 + i);
            in_valid = 1'b1;
            tick();
            model_push(in_data);
        end
        in_valid = 1'b0;
        drain("t8");
        check("t8_pulses", done_q.size() - d0, 32'd1);
        compare("t8");

        check("protocol", proto_err, 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
